// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, one result consumer and the arbiter.
// Ports: requester valid/ready/operands/select per port, result valid/ready/value/id, busy.
interface alu_arbiter_if #(
    parameter int p_width = 6
);
    logic               i_w_valid0;
    logic               i_w_valid1;
    logic [p_width:0]   i_w_a0;
    logic [p_width:0]   i_w_b0;
    logic [p_width:0]   i_w_a1;
    logic [p_width:0]   i_w_b1;
    logic               i_w_sel0;
    logic               i_w_sel1;
    logic               o_w_ready0;
    logic               o_w_ready1;
    logic               o_w_res_valid;
    logic               i_w_res_ready;
    logic [2*p_width:0] o_w_res;
    logic               o_w_res_id;
    logic               o_w_busy;

    modport master (
        output i_w_valid0, i_w_valid1,
        output i_w_a0, i_w_b0, i_w_a1, i_w_b1,
        output i_w_sel0, i_w_sel1,
        output i_w_res_ready,
        input  o_w_ready0, o_w_ready1,
        input  o_w_res_valid, o_w_res, o_w_res_id,
        input  o_w_busy
    );

    modport slave (
        input  i_w_valid0, i_w_valid1,
        input  i_w_a0, i_w_b0, i_w_a1, i_w_b1,
        input  i_w_sel0, i_w_sel1,
        input  i_w_res_ready,
        output o_w_ready0, o_w_ready1,
        output o_w_res_valid, o_w_res, o_w_res_id,
        output o_w_busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one add/multiply ALU; round-robin on contention.
// Ports: i_w_clk, i_w_rst_n (sync, active-low), bus (alu_arbiter_if.slave).

// Unsigned add or multiply, result truncated to 2*p_width+1 bits.
module alu #(
    parameter int p_width = 6
) (
    input  logic [p_width:0]   i_w_a,
    input  logic [p_width:0]   i_w_b,
    input  logic               i_w_sel,
    output logic [2*p_width:0] o_w_res
);
    localparam int rw = 2 * p_width + 1;

    logic [rw-1:0] a_ext;
    logic [rw-1:0] b_ext;

    assign a_ext   = rw'(i_w_a);
    assign b_ext   = rw'(i_w_b);
    assign o_w_res = i_w_sel ? a_ext * b_ext : a_ext + b_ext;
endmodule

module alu_arbiter #(
    parameter int p_width = 6
) (
    input  logic          i_w_clk,
    input  logic          i_w_rst_n,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               ptr_q;
    logic               ptr_d;
    logic               grant0;
    logic               grant1;
    logic               load_res;
    logic               clr_res;
    logic [p_width:0]   a_q;
    logic [p_width:0]   b_q;
    logic               sel_q;
    logic               id_q;
    logic [2*p_width:0] alu_res;
    logic [2*p_width:0] res_q;
    logic               res_id_q;
    logic               res_valid_q;

    alu #(.p_width(p_width)) u_alu (
        .i_w_a   (a_q),
        .i_w_b   (b_q),
        .i_w_sel (sel_q),
        .o_w_res (alu_res)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant0   = 1'b0;
        grant1   = 1'b0;
        load_res = 1'b0;
        clr_res  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // ptr_q names the port that wins a tie
                grant0 = bus.i_w_valid0 & (~bus.i_w_valid1 | ~ptr_q);
                grant1 = bus.i_w_valid1 & (~bus.i_w_valid0 | ptr_q);
                if (grant0 | grant1) begin
                    state_d = EXEC;
                    ptr_d   = grant0;
                end
            end
            EXEC: begin
                load_res = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                if (bus.i_w_res_ready) begin
                    clr_res = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_w_clk) begin
        if (!i_w_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge i_w_clk) begin
        if (!i_w_rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= 1'b0;
            id_q        <= 1'b0;
            res_q       <= '0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            if (grant0) begin
                a_q   <= bus.i_w_a0;
                b_q   <= bus.i_w_b0;
                sel_q <= bus.i_w_sel0;
                id_q  <= 1'b0;
            end else if (grant1) begin
                a_q   <= bus.i_w_a1;
                b_q   <= bus.i_w_b1;
                sel_q <= bus.i_w_sel1;
                id_q  <= 1'b1;
            end
            if (load_res) begin
                res_q       <= alu_res;
                res_id_q    <= id_q;
                res_valid_q <= 1'b1;
            end
            if (clr_res) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    // Reset gates the combinational outputs so nothing is offered mid-reset.
    assign bus.o_w_ready0    = i_w_rst_n & grant0;
    assign bus.o_w_ready1    = i_w_rst_n & grant1;
    assign bus.o_w_busy      = i_w_rst_n & (state_q != IDLE);
    assign bus.o_w_res       = res_q;
    assign bus.o_w_res_id    = res_id_q;
    assign bus.o_w_res_valid = res_valid_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run.
// Expected values come from constants and a transaction-level reference model.
module tb_alu_arbiter;
    localparam int pw = 6;
    localparam int rw = 2 * pw + 1;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    alu_arbiter_if #(.p_width(pw)) bus ();

    alu_arbiter #(.p_width(pw)) dut (
        .i_w_clk   (clk),
        .i_w_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [rw-1:0] ref_res(int a, int b, bit sel);
        int r;
        r = sel ? a * b : a + b;
        return rw'(r % (1 << rw));
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.i_w_valid0 = 1'b0;
        bus.i_w_valid1 = 1'b0;
        bus.i_w_a0     = '0;
        bus.i_w_b0     = '0;
        bus.i_w_a1     = '0;
        bus.i_w_b1     = '0;
        bus.i_w_sel0   = 1'b0;
        bus.i_w_sel1   = 1'b0;
    endtask

    task automatic drive0(int a, int b, bit sel);
        bus.i_w_valid0 = 1'b1;
        bus.i_w_a0     = 7'(a);
        bus.i_w_b0     = 7'(b);
        bus.i_w_sel0   = sel;
    endtask

    task automatic drive1(int a, int b, bit sel);
        bus.i_w_valid1 = 1'b1;
        bus.i_w_a1     = 7'(a);
        bus.i_w_b1     = 7'(b);
        bus.i_w_sel1   = sel;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive0(3, 3, 1'b0);
        drive1(4, 4, 1'b1);
        bus.i_w_res_ready = 1'b1;
        tick();
        tick();
        vectors++;
        if ({bus.o_w_ready0, bus.o_w_ready1, bus.o_w_res_valid,
             bus.o_w_busy, bus.o_w_res_id} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got r0=%b r1=%b rv=%b busy=%b id=%b want 0",
                     bus.o_w_ready0, bus.o_w_ready1, bus.o_w_res_valid,
                     bus.o_w_busy, bus.o_w_res_id);
        end
        vectors++;
        if (bus.o_w_res !== '0) begin
            miscompares++;
            $display("FAIL reset_res got %0d want 0", bus.o_w_res);
        end
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        drive0(5, 7, 1'b0);
        bus.i_w_res_ready = 1'b1;
        #1;
        vectors++;
        if ({bus.o_w_ready0, bus.o_w_ready1} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_grant got %b%b want 10",
                     bus.o_w_ready0, bus.o_w_ready1);
        end
        tick();
        idle_inputs();
        vectors++;
        if ({bus.o_w_ready0, bus.o_w_res_valid, bus.o_w_busy} !== 3'b001) begin
            miscompares++;
            $display("FAIL single_exec got r0=%b rv=%b busy=%b want 0 0 1",
                     bus.o_w_ready0, bus.o_w_res_valid, bus.o_w_busy);
        end
        tick();
        vectors++;
        if ({bus.o_w_res_valid, bus.o_w_res_id, bus.o_w_res}
            !== {1'b1, 1'b0, rw'(12)}) begin
            miscompares++;
            $display("FAIL single_done got rv=%b id=%b res=%0d want 1 0 12",
                     bus.o_w_res_valid, bus.o_w_res_id, bus.o_w_res);
        end
        tick();
        vectors++;
        if ({bus.o_w_res_valid, bus.o_w_busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL single_release got rv=%b busy=%b want 0 0",
                     bus.o_w_res_valid, bus.o_w_busy);
        end
    endtask

    task automatic test_ops();
        int t_port [4] = '{1, 1, 1, 0};
        int t_a    [4] = '{15, 127, 127, 100};
        int t_b    [4] = '{15, 127, 127, 3};
        int t_sel  [4] = '{1, 1, 0, 1};
        int t_exp  [4] = '{225, 7937, 254, 300};
        logic [1:0] want_rdy;
        bus.i_w_res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (t_port[i] == 1) drive1(t_a[i], t_b[i], t_sel[i] == 1);
            else drive0(t_a[i], t_b[i], t_sel[i] == 1);
            want_rdy = (t_port[i] == 1) ? 2'b01 : 2'b10;
            #1;
            vectors++;
            if ({bus.o_w_ready0, bus.o_w_ready1} !== want_rdy) begin
                miscompares++;
                $display("FAIL ops_grant[%0d] got %b%b want %b", i,
                         bus.o_w_ready0, bus.o_w_ready1, want_rdy);
            end
            tick();
            idle_inputs();
            tick();
            vectors++;
            if ({bus.o_w_res_valid, bus.o_w_res_id, bus.o_w_res}
                !== {1'b1, 1'(t_port[i]), rw'(t_exp[i])}) begin
                miscompares++;
                $display("FAIL ops_res[%0d] got rv=%b id=%b res=%0d want 1 %0d %0d",
                         i, bus.o_w_res_valid, bus.o_w_res_id, bus.o_w_res,
                         t_port[i], t_exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int e_res [4] = '{3, 12, 3, 12};
        int e_id  [4] = '{0, 1, 0, 1};
        logic [rw-1:0] got_res [4];
        logic          got_id  [4];
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            got_res[i] = 'x;
            got_id[i]  = 1'bx;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive0(1, 2, 1'b0);
        drive1(3, 4, 1'b1);
        bus.i_w_res_ready = 1'b1;
        for (int c = 0; c < 30 && n < 4; c++) begin
            tick();
            if (bus.o_w_res_valid === 1'b1) begin
                got_res[n] = bus.o_w_res;
                got_id[n]  = bus.o_w_res_id;
                n++;
            end
        end
        idle_inputs();
        vectors++;
        if (n != 4) begin
            miscompares++;
            $display("FAIL b2b_timeout got %0d results want 4", n);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({got_id[i], got_res[i]} !== {1'(e_id[i]), rw'(e_res[i])}) begin
                miscompares++;
                $display("FAIL b2b_order[%0d] got id=%b res=%0d want %0d %0d",
                         i, got_id[i], got_res[i], e_id[i], e_res[i]);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_backpressure();
        bus.i_w_res_ready = 1'b0;
        drive0(9, 9, 1'b1);
        #1;
        vectors++;
        if (bus.o_w_ready0 !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_grant got r0=%b want 1", bus.o_w_ready0);
        end
        tick();
        idle_inputs();
        drive1(2, 2, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({bus.o_w_res_valid, bus.o_w_res_id, bus.o_w_res,
                 bus.o_w_ready0, bus.o_w_ready1, bus.o_w_busy}
                !== {1'b1, 1'b0, rw'(81), 1'b0, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] got rv=%b id=%b res=%0d r0=%b r1=%b busy=%b want 1 0 81 0 0 1",
                         i, bus.o_w_res_valid, bus.o_w_res_id, bus.o_w_res,
                         bus.o_w_ready0, bus.o_w_ready1, bus.o_w_busy);
            end
            tick();
        end
        bus.i_w_res_ready = 1'b1;
        tick();
        vectors++;
        if ({bus.o_w_res_valid, bus.o_w_busy, bus.o_w_ready1} !== 3'b001) begin
            miscompares++;
            $display("FAIL bp_release got rv=%b busy=%b r1=%b want 0 0 1",
                     bus.o_w_res_valid, bus.o_w_busy, bus.o_w_ready1);
        end
        idle_inputs();
        tick();
        vectors++;
        if (bus.o_w_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_withdraw got busy=%b want 0", bus.o_w_busy);
        end
    endtask

    task automatic test_reset_exec();
        bus.i_w_res_ready = 1'b1;
        drive0(6, 6, 1'b0);
        tick();
        rst_n = 1'b0;
        drive0(1, 1, 1'b0);
        drive1(1, 1, 1'b1);
        #1;
        vectors++;
        if ({bus.o_w_ready0, bus.o_w_ready1, bus.o_w_busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_exec_comb got r0=%b r1=%b busy=%b want 0 0 0",
                     bus.o_w_ready0, bus.o_w_ready1, bus.o_w_busy);
        end
        tick();
        vectors++;
        if ({bus.o_w_ready0, bus.o_w_ready1, bus.o_w_res_valid, bus.o_w_busy,
             bus.o_w_res_id, bus.o_w_res} !== '0) begin
            miscompares++;
            $display("FAIL rst_exec_clear got r0=%b r1=%b rv=%b busy=%b id=%b res=%0d want all 0",
                     bus.o_w_ready0, bus.o_w_ready1, bus.o_w_res_valid,
                     bus.o_w_busy, bus.o_w_res_id, bus.o_w_res);
        end
        idle_inputs();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({bus.o_w_res_valid, bus.o_w_busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL rst_exec_drop[%0d] got rv=%b busy=%b want 0 0",
                         i, bus.o_w_res_valid, bus.o_w_busy);
            end
        end
        drive0(7, 8, 1'b0);
        drive1(2, 3, 1'b1);
        #1;
        vectors++;
        if ({bus.o_w_ready0, bus.o_w_ready1} !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_exec_regrant got %b%b want 10",
                     bus.o_w_ready0, bus.o_w_ready1);
        end
        tick();
        idle_inputs();
        tick();
        vectors++;
        if ({bus.o_w_res_valid, bus.o_w_res_id, bus.o_w_res}
            !== {1'b1, 1'b0, rw'(15)}) begin
            miscompares++;
            $display("FAIL rst_exec_res got rv=%b id=%b res=%0d want 1 0 15",
                     bus.o_w_res_valid, bus.o_w_res_id, bus.o_w_res);
        end
        tick();
    endtask

    task automatic test_random();
        bit            p0 = 0;
        bit            p1 = 0;
        int            a0 = 0, b0 = 0, a1 = 0, b1 = 0;
        bit            s0 = 0, s1 = 0;
        bit            m_ptr = 0;
        bit            inflight = 0;
        int            acc = 0;
        logic [rw-1:0] m_res = '0;
        bit            m_id = 0;
        bit            e_r0, e_r1, e_rv;
        rst_n = 1'b0;
        idle_inputs();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!p0 && $urandom_range(2) == 0) begin
                p0 = 1;
                a0 = int'($urandom_range(127));
                b0 = int'($urandom_range(127));
                s0 = $urandom_range(1) == 1;
            end else if (p0 && $urandom_range(9) == 0) begin
                p0 = 0;
            end
            if (!p1 && $urandom_range(2) == 0) begin
                p1 = 1;
                a1 = int'($urandom_range(127));
                b1 = int'($urandom_range(127));
                s1 = $urandom_range(1) == 1;
            end else if (p1 && $urandom_range(9) == 0) begin
                p1 = 0;
            end
            bus.i_w_valid0    = p0;
            bus.i_w_a0        = 7'(a0);
            bus.i_w_b0        = 7'(b0);
            bus.i_w_sel0      = s0;
            bus.i_w_valid1    = p1;
            bus.i_w_a1        = 7'(a1);
            bus.i_w_b1        = 7'(b1);
            bus.i_w_sel1      = s1;
            bus.i_w_res_ready = $urandom_range(1) == 1;
            #1;
            e_r0 = !inflight && p0 && (!p1 || !m_ptr);
            e_r1 = !inflight && p1 && (!p0 || m_ptr);
            e_rv = inflight && (c - acc >= 2);
            vectors++;
            if ({bus.o_w_ready0, bus.o_w_ready1, bus.o_w_res_valid, bus.o_w_busy}
                !== {e_r0, e_r1, e_rv, inflight}) begin
                miscompares++;
                $display("FAIL rand_ctrl c=%0d got r0=%b r1=%b rv=%b busy=%b want %b %b %b %b",
                         c, bus.o_w_ready0, bus.o_w_ready1, bus.o_w_res_valid,
                         bus.o_w_busy, e_r0, e_r1, e_rv, inflight);
            end
            if (e_rv) begin
                vectors++;
                if ({bus.o_w_res_id, bus.o_w_res} !== {m_id, m_res}) begin
                    miscompares++;
                    $display("FAIL rand_res c=%0d got id=%b res=%0d want %b %0d",
                             c, bus.o_w_res_id, bus.o_w_res, m_id, m_res);
                end
                if (bus.i_w_res_ready) inflight = 0;
            end
            if (e_r0 || e_r1) begin
                inflight = 1;
                acc      = c;
                m_id     = e_r1;
                m_res    = e_r1 ? ref_res(a1, b1, s1) : ref_res(a0, b0, s0);
                m_ptr    = e_r0;
                if (e_r0) p0 = 0;
                else p1 = 0;
            end
            tick();
        end
        idle_inputs();
        bus.i_w_res_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        bus.i_w_res_ready = 1'b0;
        test_reset();
        test_single();
        test_ops();
        test_back_to_back();
        test_backpressure();
        test_reset_exec();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
